// File: rtl/pkt_gap_ctrl.sv
// TX-path gap controller: forwards pad's ctrl/data stream through a 4-entry
// fallthrough FIFO, inserts idle cycles after each EOP and can stop after N packets.
module pkt_gap_ctrl #(
   parameter int DATA_WIDTH       = 64,
   parameter int CTRL_WIDTH       = DATA_WIDTH / 8,
   parameter int GAP_WIDTH        = 32,
   parameter int CNT_WIDTH        = 32,
   parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = {CTRL_WIDTH{1'b1}},
   parameter int IOQ_BYTE_LEN_POS = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  in_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   input  logic                  enable,
   input  logic [GAP_WIDTH-1:0]  gap_cycles,
   input  logic [CNT_WIDTH-1:0]  max_pkts,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  pkt_count,
   output logic [CNT_WIDTH-1:0]  byte_count,
   output logic [1:0]            dbg_state
);

   localparam int FIFO_DEPTH = 4;
   localparam int PTR_W      = 2;
   localparam int WORD_W     = CTRL_WIDTH + DATA_WIDTH;

   localparam logic [PTR_W-1:0]     PTR_ONE    = 1;
   localparam logic [PTR_W:0]       FCNT_ONE   = 1;
   localparam logic [PTR_W:0]       FCNT_FULL  = 4;
   localparam logic [PTR_W:0]       FCNT_NFULL = 3;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = 1;
   localparam logic [GAP_WIDTH-1:0] GAP_ONE    = 1;

   typedef enum logic [1:0] {
      S_HDR  = 2'd0,
      S_BODY = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t                 state;
   logic                   sop_taken;
   logic [15:0]            cur_len;
   logic [GAP_WIDTH-1:0]   gap_cnt;
   logic [CNT_WIDTH-1:0]   sess_cnt;
   logic [CNT_WIDTH-1:0]   sess_next;

   logic [WORD_W-1:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W:0]         fifo_cnt;
   logic                   fifo_empty;
   logic                   fifo_full;
   logic [CTRL_WIDTH-1:0]  head_ctrl;
   logic [DATA_WIDTH-1:0]  head_data;

   logic                   rd_permit;
   logic                   rd_en;
   logic                   wr_en;

   // Handshake: a word transfers on the input when in_wr=1 (in_rdy is a
   // one-cycle-ahead credit), and on the output when out_wr=1 (out_rdy gates reads).
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == FCNT_FULL);
   assign in_rdy     = (fifo_cnt < FCNT_NFULL);
   assign head_ctrl  = fifo_mem[rd_ptr][WORD_W-1 -: CTRL_WIDTH];
   assign head_data  = fifo_mem[rd_ptr][DATA_WIDTH-1:0];
   assign wr_en      = in_wr && !fifo_full;
   assign sess_next  = sess_cnt + CNT_ONE;
   assign dbg_state  = state;

   // Once a packet's first word is taken, the rest follows regardless of enable.
   always_comb begin
      rd_permit = 1'b0;
      case (state)
         S_HDR:   rd_permit = sop_taken || (enable && !done);
         S_BODY:  rd_permit = 1'b1;
         default: rd_permit = 1'b0;
      endcase
   end

   assign rd_en = !fifo_empty && out_rdy && rd_permit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (wr_en) begin
            fifo_mem[wr_ptr] <= {in_ctrl, in_data};
            wr_ptr           <= wr_ptr + PTR_ONE;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({wr_en, rd_en})
            2'b10:   fifo_cnt <= fifo_cnt + FCNT_ONE;
            2'b01:   fifo_cnt <= fifo_cnt - FCNT_ONE;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_HDR;
         sop_taken  <= 1'b0;
         cur_len    <= '0;
         gap_cnt    <= '0;
         sess_cnt   <= '0;
         done       <= 1'b0;
         pkt_count  <= '0;
         byte_count <= '0;
         out_data   <= '0;
         out_ctrl   <= '0;
         out_wr     <= 1'b0;
      end else begin
         out_wr <= rd_en;
         if (rd_en) begin
            out_data <= head_data;
            out_ctrl <= head_ctrl;
         end

         if (!enable) begin
            sess_cnt <= '0;
            done     <= 1'b0;
         end

         case (state)
            S_HDR: begin
               if (rd_en) begin
                  sop_taken <= 1'b1;
                  if (head_ctrl == IO_QUEUE_STAGE_NUM) begin
                     cur_len <= head_data[IOQ_BYTE_LEN_POS +: 16];
                  end
                  if (head_ctrl == '0) begin
                     state <= S_BODY;
                  end
               end
            end

            S_BODY: begin
               if (rd_en && (head_ctrl != '0)) begin
                  sop_taken  <= 1'b0;
                  pkt_count  <= pkt_count + CNT_ONE;
                  byte_count <= byte_count + CNT_WIDTH'(cur_len);
                  if (enable) begin
                     sess_cnt <= sess_next;
                     if ((max_pkts != '0) && (sess_next == max_pkts)) begin
                        done <= 1'b1;
                     end
                  end
                  if (gap_cycles == '0) begin
                     state <= S_HDR;
                  end else begin
                     gap_cnt <= gap_cycles;
                     state   <= S_GAP;
                  end
               end
            end

            // Counts down even while out_rdy=0, so a stalled output never lengthens the gap.
            S_GAP: begin
               gap_cnt <= gap_cnt - GAP_ONE;
               if (gap_cnt == GAP_ONE) begin
                  state <= S_HDR;
               end
            end

            default: state <= S_HDR;
         endcase
      end
   end

endmodule

// File: tb/tb_pkt_gap_ctrl.sv
// Bench for pkt_gap_ctrl: packet-level scoreboard, gap measurement and counter
// model driven from random packet contents and random output back-pressure.
module tb_pkt_gap_ctrl;

   localparam int DW = 64;
   localparam int CW = 8;
   localparam int GW = 32;
   localparam int NW = 32;
   localparam int W  = 2 + CW + DW;

   logic           clk = 1'b0;
   logic           reset;
   logic [DW-1:0]  in_data;
   logic [CW-1:0]  in_ctrl;
   logic           in_wr;
   logic           in_rdy;
   logic [DW-1:0]  out_data;
   logic [CW-1:0]  out_ctrl;
   logic           out_wr;
   logic           out_rdy;
   logic           enable;
   logic [GW-1:0]  gap_cycles;
   logic [NW-1:0]  max_pkts;
   logic           done;
   logic [NW-1:0]  pkt_count;
   logic [NW-1:0]  byte_count;
   logic [1:0]     dbg_state;

   pkt_gap_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_ctrl    (in_ctrl),
      .in_wr      (in_wr),
      .in_rdy     (in_rdy),
      .out_data   (out_data),
      .out_ctrl   (out_ctrl),
      .out_wr     (out_wr),
      .out_rdy    (out_rdy),
      .enable     (enable),
      .gap_cycles (gap_cycles),
      .max_pkts   (max_pkts),
      .done       (done),
      .pkt_count  (pkt_count),
      .byte_count (byte_count),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [W-1:0]       exp_q[$];   // {sop, eop, ctrl, data}
   logic [CW+DW-1:0]   in_q[$];
   int                 len_q[$];
   int                 gap_q[$];
   int                 n_checks = 0;
   int                 n_pass   = 0;
   int                 n_wr     = 0;
   int                 first_cyc = 0;
   int                 last_cyc  = 0;
   int                 eop_cyc   = 0;
   bit                 have_eop  = 0;
   bit                 rnd_rdy   = 0;
   logic [NW-1:0]      m_pkt   = '0;
   logic [NW-1:0]      m_bytes = '0;
   logic [NW-1:0]      m_sess  = '0;
   logic               m_done  = 1'b0;

   task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // ---------------- driver tasks ----------------
   initial begin
      in_wr   = 1'b0;
      in_data = '0;
      in_ctrl = '0;
      forever begin
         @(negedge clk);
         if (reset && in_q.size() > 0 && in_rdy) begin
            {in_ctrl, in_data} = in_q.pop_front();
            in_wr = 1'b1;
         end else begin
            in_wr = 1'b0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (rnd_rdy) out_rdy = ($urandom_range(0, 1) == 1);
   end

   task automatic push_word(input logic [7:0] c, input logic [63:0] d,
                            input bit sop, input bit eop, input bit expect_out);
      in_q.push_back({c, d});
      if (expect_out) exp_q.push_back({sop, eop, c, d});
   endtask

   task automatic send_pkt(input int nbytes);
      int          nw;
      logic [63:0] d;
      logic [7:0]  ec;
      nw = (nbytes + 7) / 8;
      ec = 8'h01 << ((nbytes - 1) % 8);
      d  = {$urandom, 16'($urandom), 16'(nbytes)};
      push_word(8'hff, d, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < nw; i++) begin
         d = {$urandom, $urandom};
         if (i == nw - 1) push_word(ec, d, 1'b0, 1'b1, 1'b1);
         else             push_word(8'h00, d, 1'b0, 1'b0, 1'b1);
      end
      len_q.push_back(nbytes);
   endtask

   task automatic wait_drain(input int budget, input string tag);
      for (int i = 0; i < budget && (exp_q.size() != 0 || in_q.size() != 0); i++)
         @(negedge clk);
      check_eq(tag, exp_q.size(), 0);
   endtask

   task automatic clr_obs();
      gap_q.delete();
      have_eop = 0;
      n_wr     = 0;
   endtask

   task automatic new_session();
      @(negedge clk);
      enable = 1'b0;
      m_sess = '0;
      m_done = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("done_cleared", done, 0);
      enable = 1'b1;
   endtask

   // ---------------- monitor / reference model ----------------
   initial forever begin
      logic [W-1:0] e;
      @(negedge clk);
      if (out_wr) begin
         n_wr++;
         if (n_wr == 1) first_cyc = cyc;
         last_cyc = cyc;
         if (exp_q.size() == 0) begin
            check_eq("spurious_wr", {out_ctrl, out_data}, 0);
         end else begin
            e = exp_q.pop_front();
            check_eq("word", {out_ctrl, out_data}, e[CW+DW-1:0]);
            if (e[W-1] && have_eop) gap_q.push_back(cyc - eop_cyc - 1);
            if (e[W-2]) begin
               eop_cyc  = cyc;
               have_eop = 1;
               m_pkt    = m_pkt + 1;
               m_bytes  = m_bytes + NW'(len_q.pop_front());
               if (!enable) begin
                  m_sess = '0;
                  m_done = 1'b0;
               end else begin
                  m_sess = m_sess + 1;
                  if (max_pkts != 0 && m_sess == max_pkts) m_done = 1'b1;
               end
               check_eq("pkt_count", pkt_count, m_pkt);
               check_eq("byte_count", byte_count, m_bytes);
               check_eq("done_at_eop", done, m_done);
            end
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      int pre;
      reset      = 1'b0;
      enable     = 1'b0;
      out_rdy    = 1'b1;
      gap_cycles = '0;
      max_pkts   = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_out_wr", out_wr, 0);
      check_eq("rst_pkt_count", pkt_count, 0);
      check_eq("rst_byte_count", byte_count, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_in_rdy", in_rdy, 1);
      check_eq("rst_out_word", {out_ctrl, out_data}, 0);
      reset = 1'b1;

      // back-to-back packets with no gap
      enable = 1'b1;
      clr_obs();
      send_pkt(64);
      send_pkt(64);
      wait_drain(300, "t2_drain");
      check_eq("t2_words", n_wr, 18);
      check_eq("t2_contiguous", last_cyc - first_cyc + 1, 18);
      check_eq("t2_gaps", gap_q.size(), 1);
      if (gap_q.size() > 0) check_eq("t2_gap0", gap_q[0], 0);
      check_eq("t2_pkts", pkt_count, 2);
      check_eq("t2_bytes", byte_count, 128);

      // programmed 5-cycle gap
      gap_cycles = 5;
      clr_obs();
      send_pkt(64);
      send_pkt(64);
      wait_drain(300, "t3_drain");
      check_eq("t3_gaps", gap_q.size(), 1);
      if (gap_q.size() > 0) check_eq("t3_gap5", gap_q[0], 5);
      repeat (10) @(negedge clk);

      // reset in the middle of a packet
      gap_cycles = 0;
      clr_obs();
      push_word(8'hff, 64'h0000_abcd_0000_0040, 1'b1, 1'b0, 1'b1);
      push_word(8'h00, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 100 && n_wr < 2; i++) @(negedge clk);
      check_eq("t1_head_words", n_wr, 2);
      out_rdy = 1'b0;
      for (int i = 0; i < 3; i++) push_word(8'h00, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 50 && in_q.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check_eq("t1_nearly_full", in_rdy, 0);
      reset = 1'b0;
      #1;
      check_eq("t1_out_wr", out_wr, 0);
      check_eq("t1_pkt_count", pkt_count, 0);
      check_eq("t1_byte_count", byte_count, 0);
      check_eq("t1_in_rdy", in_rdy, 1);
      check_eq("t1_exp_empty", exp_q.size(), 0);
      @(negedge clk);
      reset   = 1'b1;
      out_rdy = 1'b1;
      m_pkt   = '0;
      m_bytes = '0;
      m_sess  = '0;
      m_done  = 1'b0;
      send_pkt(72);
      wait_drain(300, "t1_after_drain");

      // packet limit per session
      max_pkts   = 3;
      gap_cycles = 2;
      new_session();
      clr_obs();
      for (int i = 0; i < 5; i++) send_pkt(64);
      for (int i = 0; i < 500 && exp_q.size() > 18; i++) @(negedge clk);
      repeat (40) @(negedge clk);
      check_eq("t4_held_words", exp_q.size(), 18);
      check_eq("t4_words_out", n_wr, 27);
      check_eq("t4_done", done, 1);
      new_session();
      send_pkt(64);
      wait_drain(600, "t4_drain");
      check_eq("t4_done_again", done, 1);
      check_eq("t4_pkts", pkt_count, m_pkt);

      // enable dropped mid-packet
      max_pkts   = 0;
      gap_cycles = 0;
      new_session();
      clr_obs();
      send_pkt(64);
      for (int i = 0; i < 100 && n_wr < 3; i++) @(negedge clk);
      enable = 1'b0;
      m_sess = '0;
      m_done = 1'b0;
      wait_drain(300, "t5_finish_pkt");
      pre = n_wr;
      send_pkt(64);
      repeat (40) @(negedge clk);
      check_eq("t5_no_sop", n_wr, pre);
      check_eq("t5_pending", exp_q.size(), 9);
      enable = 1'b1;
      wait_drain(300, "t5_drain");

      // random back-pressure and counter wrap
      gap_cycles = 1;
      @(negedge clk);
      force dut.pkt_count = 32'hffff_fffe;
      @(negedge clk);
      release dut.pkt_count;
      m_pkt = 32'hffff_fffe;
      clr_obs();
      rnd_rdy = 1;
      for (int i = 0; i < 4; i++) send_pkt($urandom_range(60, 200));
      wait_drain(4000, "t6_drain");
      rnd_rdy = 0;
      @(negedge clk);
      out_rdy = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("t6_wrapped", pkt_count, m_pkt);
      check_eq("t6_bytes", byte_count, m_bytes);
      check_eq("t6_no_extra", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
